// File: rtl/matrix_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_fetch_unit_if
//  Description : Memory and coprocessor bus bundle for the matrix fetch unit.
//                The master modport is the fetch unit and the slave modport
//                is the memory / coprocessor side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_fetch_unit_if #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int ADDR_W  = 8
);
    localparam int c_FLAT_W = MAX_DIM * MAX_DIM * DATA_W;

    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_wr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                cp_start;
    logic [2:0]          cp_op;
    logic [1:0]          cp_size;
    logic [c_FLAT_W-1:0] cp_a;
    logic [c_FLAT_W-1:0] cp_b;
    logic [c_FLAT_W-1:0] cp_result;
    logic                cp_done;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        output cp_start, cp_op, cp_size, cp_a, cp_b,
        input  mem_rdata, cp_result, cp_done
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        input  cp_start, cp_op, cp_size, cp_a, cp_b,
        output mem_rdata, cp_result, cp_done
    );
endinterface
`default_nettype wire

// File: rtl/matrix_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_fetch_unit
//  Description : Streams matrix A (and B when the opcode needs it) from memory
//                into flat operand buses, launches the matrix coprocessor,
//                waits for completion and writes the result back to memory.
//                Optional build macro MATRIX_FETCH_PERF_EN adds the
//                perf_cycles / perf_ops counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_fetch_unit #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic [2:0]        op,
    input  wire logic [1:0]        size,
    input  wire logic [ADDR_W-1:0] base_a,
    input  wire logic [ADDR_W-1:0] base_b,
    input  wire logic [ADDR_W-1:0] base_r,
    matrix_fetch_unit_if.master    bus,
    output logic                   busy,
    output logic                   done,
`ifdef MATRIX_FETCH_PERF_EN
    output logic [15:0]            perf_cycles,
    output logic [15:0]            perf_ops,
`endif
    output logic                   error
);

    localparam int c_NUM_EL = MAX_DIM * MAX_DIM;
    localparam int c_CNT_W  = $clog2(c_NUM_EL + 1);
    localparam int c_FLAT_W = c_NUM_EL * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_B = 3'd2,
        S_LAUNCH  = 3'd3,
        S_WAIT_CP = 3'd4,
        S_WRITE   = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    state_t                              r_state;
    state_t                              w_next_state;

    logic [2:0]                          r_op;
    logic [1:0]                          r_size;
    logic [ADDR_W-1:0]                   r_base_a;
    logic [ADDR_W-1:0]                   r_base_b;
    logic [ADDR_W-1:0]                   r_base_r;
    logic [c_CNT_W-1:0]                  r_n;
    logic [c_CNT_W-1:0]                  r_fetch_n;
    logic [c_CNT_W-1:0]                  r_issue_cnt;
    logic [c_CNT_W-1:0]                  r_wr_cnt;
    logic [MEM_LAT-1:0]                  r_vld;
    logic [MEM_LAT-1:0][c_CNT_W-1:0]     r_tag;
    logic [c_FLAT_W-1:0]                 r_cp_a;
    logic [c_FLAT_W-1:0]                 r_cp_b;
    logic [c_FLAT_W-1:0]                 r_result;
    logic                                r_error;

    logic [2:0]                          w_dim;
    logic [5:0]                          w_n_full;
    logic                                w_illegal;
    logic                                w_accept;
    logic                                w_fetching;
    logic                                w_issue;
    logic                                w_cap;
    logic                                w_last_cap;
    logic [c_CNT_W-1:0]                  w_wr_n;
    logic [DATA_W-1:0]                   w_wr_elem;
    logic [ADDR_W-1:0]                   w_mem_addr;
    logic                                w_mem_rd;
    logic                                w_mem_wr;
    logic [DATA_W-1:0]                   w_mem_wdata;
    logic                                w_cp_start;
    logic                                w_done;

    // Request decode: element count and legality of the incoming op/size.
    assign w_dim      = {1'b0, size} + 3'd2;
    assign w_n_full   = {3'b000, w_dim} * {3'b000, w_dim};
    assign w_illegal  = (op[2:1] == 2'b11) || (32'(w_dim) > MAX_DIM);
    assign w_accept   = (r_state == S_IDLE) && start && !w_illegal;

    // Fetch control: reads are issued in order, so the tag of the final
    // read reaching the pipeline end marks the last captured datum.
    assign w_fetching = (r_state == S_FETCH_A) || (r_state == S_FETCH_B);
    assign w_issue    = w_fetching && (r_issue_cnt < r_fetch_n);
    assign w_cap      = w_fetching && r_vld[MEM_LAT-1];
    assign w_last_cap = w_cap && (r_tag[MEM_LAT-1] == r_fetch_n - c_CNT_W'(1));

    // Determinant writes back a single scalar; every other op writes n.
    assign w_wr_n     = (r_op == 3'b101) ? c_CNT_W'(1) : r_n;

    // Select the result element currently being written back.
    always_comb begin
        w_wr_elem = '0;
        for (int k = 0; k < c_NUM_EL; k++) begin
            if (r_wr_cnt == c_CNT_W'(k)) begin
                w_wr_elem = r_result[k*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and bus strobe decode.
    always_comb begin
        w_next_state = r_state;
        w_mem_addr   = '0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_mem_wdata  = '0;
        w_cp_start   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_FETCH_A;
                end
            end
            S_FETCH_A: begin
                w_mem_rd = w_issue;
                if (w_issue) begin
                    w_mem_addr = r_base_a + ADDR_W'(r_issue_cnt);
                end
                if (w_last_cap) begin
                    // Unary ops (transpose, determinant) need no B operand.
                    w_next_state = r_op[2] ? S_LAUNCH : S_FETCH_B;
                end
            end
            S_FETCH_B: begin
                w_mem_rd = w_issue;
                if (w_issue) begin
                    w_mem_addr = r_base_b + ADDR_W'(r_issue_cnt);
                end
                if (w_last_cap) begin
                    w_next_state = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_cp_start   = 1'b1;
                w_next_state = S_WAIT_CP;
            end
            S_WAIT_CP: begin
                if (bus.cp_done) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_mem_wr    = 1'b1;
                w_mem_addr  = r_base_r + ADDR_W'(r_wr_cnt);
                w_mem_wdata = w_wr_elem;
                if (r_wr_cnt == w_wr_n - c_CNT_W'(1)) begin
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request latch, counters, error pulse and the read-tag pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op        <= '0;
            r_size      <= '0;
            r_base_a    <= '0;
            r_base_b    <= '0;
            r_base_r    <= '0;
            r_n         <= '0;
            r_fetch_n   <= '0;
            r_issue_cnt <= '0;
            r_wr_cnt    <= '0;
            r_vld       <= '0;
            r_tag       <= '0;
            r_error     <= 1'b0;
        end else begin
            r_error  <= (r_state == S_IDLE) && start && w_illegal;
            r_vld[0] <= w_issue;
            r_tag[0] <= r_issue_cnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
            if (w_accept) begin
                r_op        <= op;
                r_size      <= size;
                r_base_a    <= base_a;
                r_base_b    <= base_b;
                r_base_r    <= base_r;
                r_n         <= c_CNT_W'(w_n_full);
                r_fetch_n   <= c_CNT_W'(w_n_full);
                r_issue_cnt <= '0;
                r_wr_cnt    <= '0;
            end else if ((r_state == S_FETCH_A) && w_last_cap) begin
                // Scalar multiply only needs the single scalar from B.
                r_fetch_n   <= (r_op == 3'b011) ? c_CNT_W'(1) : r_n;
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + c_CNT_W'(1);
            end
            if (r_state == S_WRITE) begin
                r_wr_cnt <= r_wr_cnt + c_CNT_W'(1);
            end
        end
    end

    // Operand capture; operands clear on every accepted request so unused
    // elements read as zero and nothing survives from a previous op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cp_a <= '0;
            r_cp_b <= '0;
        end else if (w_accept) begin
            r_cp_a <= '0;
            r_cp_b <= '0;
        end else if (w_cap) begin
            for (int k = 0; k < c_NUM_EL; k++) begin
                if (r_tag[MEM_LAT-1] == c_CNT_W'(k)) begin
                    if (r_state == S_FETCH_A) begin
                        r_cp_a[k*DATA_W +: DATA_W] <= bus.mem_rdata;
                    end else begin
                        r_cp_b[k*DATA_W +: DATA_W] <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    // Result capture; a cp_done coincident with cp_start is never seen
    // because completion is only sampled in WAIT_CP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
        end else if ((r_state == S_WAIT_CP) && bus.cp_done) begin
            r_result <= bus.cp_result;
        end
    end

`ifdef MATRIX_FETCH_PERF_EN
    logic [15:0] r_run_cnt;
    logic [15:0] r_perf_cycles;
    logic [15:0] r_perf_ops;

    // Operation duration (saturating) and completed-operation count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_cnt     <= '0;
            r_perf_cycles <= '0;
            r_perf_ops    <= '0;
        end else begin
            if (w_accept) begin
                r_run_cnt <= 16'd1;
            end else if ((r_state != S_IDLE) && (r_run_cnt != 16'hFFFF)) begin
                r_run_cnt <= r_run_cnt + 16'd1;
            end
            if (r_state == S_FINISH) begin
                r_perf_cycles <= r_run_cnt;
                r_perf_ops    <= r_perf_ops + 16'd1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_ops    = r_perf_ops;
`endif

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.cp_start  = w_cp_start;
    assign bus.cp_op     = r_op;
    assign bus.cp_size   = r_size;
    assign bus.cp_a      = r_cp_a;
    assign bus.cp_b      = r_cp_b;
    assign busy          = (r_state != S_IDLE);
    assign done          = w_done;
    assign error         = r_error;

endmodule
`default_nettype wire
